// File: rtl/clock_tick_sched.sv
// clock_tick_sched: multi-channel clock divider with tick enables and glitch-free divisor updates.
// Define CLK_SCHED_ALIGN_EN to add the align input that phase-aligns all enabled channels.
module clock_tick_sched #(
  parameter int NCH = 4,
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  logic                   clkin,
  input  logic                   rstn,
  input  logic [NCH-1:0]         en,
  input  logic                   cfg_valid,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]       cfg_div,
`ifdef CLK_SCHED_ALIGN_EN
  input  logic                   align,
`endif
  output logic                   cfg_ready,
  output logic                   busy,
  output logic [NCH-1:0]         tick,
  output logic [NCH-1:0]         clkout
);
  localparam int CHW = $clog2(NCH);
  typedef enum logic {IDLE, APPLY} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt [NCH];
  logic [CNT_W-1:0] div [NCH];
  logic [CHW-1:0]   p_ch;
  logic [CNT_W-1:0] p_div;
  logic [NCH-1:0]   tc;
  logic             al, hit, app;
`ifdef CLK_SCHED_ALIGN_EN
  assign al = align;
`else
  assign al = 1'b0;
`endif
  always_comb begin
    tc = '0;
    for (int i = 0; i < NCH; i++) tc[i] = cnt[i] == div[i];
  end
  // a pending divisor lands only when its channel's counter restarts from 0
  assign hit = {1'b0, p_ch} < (CHW + 1)'(NCH);
  assign app = hit && (!en[p_ch] || (tc[p_ch] && !al));
  assign cfg_ready = state == IDLE;
  assign busy = state == APPLY;
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        div[i] <= CNT_W'(DEFAULT_DIV);
      end
      tick <= '0;
      clkout <= '0;
      state <= IDLE;
      p_ch <= '0;
      p_div <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!en[i] || al) begin
          cnt[i] <= '0;
          clkout[i] <= 1'b0;
          tick[i] <= 1'b0;
        end else if (tc[i]) begin
          cnt[i] <= '0;
          clkout[i] <= ~clkout[i];
          tick[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
          tick[i] <= 1'b0;
        end
      end
      if (state == IDLE) begin
        if (cfg_valid) begin
          p_ch <= cfg_ch;
          p_div <= cfg_div;
          state <= APPLY;
        end
      end else if (!hit || app) begin
        state <= IDLE;
        if (app) div[p_ch] <= p_div;
      end
    end
  end
endmodule

// File: tb/tb_clock_tick_sched.sv
// tb_clock_tick_sched: checks clock_tick_sched against an absolute-time schedule model plus directed literals.
module tb_clock_tick_sched;
  localparam int NCH = 4;
  logic           clkin = 0, rstn = 0, cfg_valid = 0, align = 0;
  logic [NCH-1:0] en = '0;
  logic [1:0]     cfg_ch = '0;
  logic [15:0]    cfg_div = '0;
  logic           cfg_ready, busy;
  logic [NCH-1:0] tick, clkout;
  int compared = 0, mismatched = 0;

  always #5 clkin = ~clkin;

  clock_tick_sched dut (
    .clkin(clkin), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef CLK_SCHED_ALIGN_EN
    .align(align),
`endif
    .cfg_ready(cfg_ready), .busy(busy), .tick(tick), .clkout(clkout)
  );

  // Model: each channel keeps the absolute edge number of its next terminal count.
  longint         k;
  longint         nxt [NCH];
  int             m_div [NCH];
  logic [NCH-1:0] m_tick, m_clk;
  bit             m_busy, m_was;
  int             pch, pdiv;

  always @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      k = 0;
      m_tick = '0;
      m_clk = '0;
      m_busy = 0;
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = 50000;
        nxt[i] = 50001;
      end
    end else begin
      k++;
      m_was = m_busy;
      if (m_busy && pch >= NCH) m_busy = 0;
      else if (m_busy && (!en[pch] || (k == nxt[pch] && !align))) begin
        m_div[pch] = pdiv;
        m_busy = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (!en[i] || align) begin
          m_clk[i] = 0;
          m_tick[i] = 0;
          nxt[i] = k + m_div[i] + 1;
        end else if (k == nxt[i]) begin
          m_clk[i] = ~m_clk[i];
          m_tick[i] = 1;
          nxt[i] = k + m_div[i] + 1;
        end else m_tick[i] = 0;
      end
      if (!m_was && cfg_valid) begin
        m_busy = 1;
        pch = int'(cfg_ch);
        pdiv = int'(cfg_div);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clkin) begin
    if (rstn) begin
      chk("model_tick", 32'(tick), 32'(m_tick));
      chk("model_clkout", 32'(clkout), 32'(m_clk));
      chk("model_cfg_ready", 32'(cfg_ready), 32'(!m_busy));
      chk("model_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic until_change(input int ch, output int n);
    logic v;
    v = clkout[ch];
    n = 0;
    do begin
      @(negedge clkin);
      n++;
    end while (clkout[ch] == v && n < 60000);
  endtask

  task automatic do_cfg(input int ch, input int d);
    cfg_valid = 1;
    cfg_ch = 2'(ch);
    cfg_div = 16'(d);
    step(1);
    cfg_valid = 0;
  endtask

  initial begin
    int n, b, t, f0, f1;
    step(2);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_clkout", 32'(clkout), 0);
    rstn = 1;
    en = 4'b0001;
    until_change(0, n);
    chk("ch0_first_rise", n, 50001);
    chk("ch0_tick_at_rise", 32'(tick[0]), 1);
    do_cfg(1, 3);
    chk("ch1_busy_on", 32'(busy), 1);
    chk("ch1_ready_off", 32'(cfg_ready), 0);
    step(1);
    chk("ch1_busy_one_cycle", 32'(busy), 0);
    en[1] = 1;
    until_change(1, n);
    chk("ch1_rise", n, 4);
    until_change(1, n);
    chk("ch1_high", n, 4);
    until_change(1, n);
    chk("ch1_low", n, 4);
    en[0] = 0;
    step(1);
    do_cfg(0, 3);
    step(1);
    en[0] = 1;
    step(1);
    do_cfg(0, 1);
    chk("ch0_ready_wait", 32'(cfg_ready), 0);
    b = 0;
    while (busy && b < 20) begin
      b++;
      step(1);
    end
    chk("ch0_busy_len", b, 2);
    chk("ch0_clk_after_switch", 32'(clkout[0]), 1);
    until_change(0, n);
    chk("ch0_half_a", n, 2);
    until_change(0, n);
    chk("ch0_half_b", n, 2);
    do_cfg(2, 3);
    step(1);
    en[2] = 1;
    step(3);
    do_cfg(2, 5);
    chk("ch2_tc_tick", 32'(tick[2]), 1);
    chk("ch2_busy_on", 32'(busy), 1);
    b = 0;
    while (busy && b < 20) begin
      b++;
      step(1);
    end
    chk("ch2_busy_len", b, 4);
    chk("ch2_clk_at_apply", 32'(clkout[2]), 0);
    until_change(2, n);
    chk("ch2_new_half", n, 6);
    do_cfg(1, 9);
    chk("rst_mid_busy", 32'(busy), 1);
    rstn = 0;
    #1;
    chk("rst_mid_clkout", 32'(clkout), 0);
    chk("rst_mid_tick", 32'(tick), 0);
    chk("rst_mid_busy_off", 32'(busy), 0);
    chk("rst_mid_ready", 32'(cfg_ready), 1);
    step(1);
    rstn = 1;
    t = 0;
    repeat (300) begin
      step(1);
      if (|tick) t++;
    end
    chk("post_reset_ticks", t, 0);
    chk("post_reset_clkout", 32'(clkout), 0);
`ifdef CLK_SCHED_ALIGN_EN
    en = '0;
    step(1);
    do_cfg(0, 3);
    step(1);
    do_cfg(1, 7);
    step(1);
    en[0] = 1;
    step(2);
    en[1] = 1;
    step(5);
    align = 1;
    step(1);
    align = 0;
    chk("align_clkout", 32'(clkout[1:0]), 0);
    chk("align_tick", 32'(tick[1:0]), 0);
    f0 = 0;
    f1 = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (f0 == 0 && clkout[0]) f0 = i;
      if (f1 == 0 && clkout[1]) f1 = i;
    end
    chk("align_ch0_rise", f0, 4);
    chk("align_ch1_rise", f1, 8);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
